// File: rtl/rv32im_bus_pkg.sv
// Shared types and helpers for the rv32im Wishbone bus arbiter.
package rv32im_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWNED   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned WB_ADR_W = XLEN_DEF - 2;
  localparam int unsigned WD_CNT_W = 16;

  // Bit offset of master k's field inside a flattened per-master vector.
  function automatic int unsigned slice(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/rv32im_rr_picker.sv
// Combinational round-robin selector: first active requester at or after ptr_i.
module rv32im_rr_picker #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned PTR_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] active_i,
  input  logic [PTR_W-1:0]       ptr_i,
  output logic [NUM_MASTERS-1:0] pick_o,
  output logic                   valid_o
);

  logic found;

  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
        if (!found && active_i[k] && (k == (32'(ptr_i) + i) % NUM_MASTERS)) begin
          pick_o[k] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

  assign valid_o = |active_i;

endmodule

// File: rtl/rv32im_bus_arbiter.sv
// Round-robin Wishbone classic arbiter for the rv32im core masters, with a
// stall watchdog that synthesizes err for hung cycles.
module rv32im_bus_arbiter
  import rv32im_bus_pkg::*;
#(
  parameter int unsigned XLEN           = XLEN_DEF,
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [NUM_MASTERS-1:0]          req_i,
  output logic [NUM_MASTERS-1:0]          grant_o,
  input  logic [NUM_MASTERS*(XLEN-2)-1:0] m_adr_i,
  input  logic [NUM_MASTERS*XLEN-1:0]     m_dat_i,
  input  logic [NUM_MASTERS*4-1:0]        m_sel_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic [XLEN-1:0]                 m_dat_o,
  output logic [XLEN-3:0]                 s_adr_o,
  output logic [XLEN-1:0]                 s_dat_o,
  output logic [3:0]                      s_sel_o,
  output logic                            s_we_o,
  output logic                            s_stb_o,
  output logic                            s_cyc_o,
  input  logic [XLEN-1:0]                 s_dat_i,
  input  logic                            s_ack_i,
  input  logic                            s_err_i,
  output logic                            timeout_o
);

  localparam int unsigned ADR_W = XLEN - 2;
  localparam int unsigned PTR_W = (NUM_MASTERS > 2) ? 2 : 1;

  arb_state_e              state_q, state_d;
  logic [NUM_MASTERS-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0]        owner_q, owner_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [WD_CNT_W-1:0]     wd_cnt_q, wd_cnt_d;

  logic [NUM_MASTERS-1:0]  active;
  logic [NUM_MASTERS-1:0]  pick;
  logic                    pick_valid;
  logic                    owner_active;
  logic                    stalled;
  logic                    wd_fire;

  assign active       = req_i | m_cyc_i;
  assign owner_active = active[owner_q];

  rv32im_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .PTR_W       (PTR_W)
  ) u_picker (
    .active_i (active),
    .ptr_i    (rr_ptr_q),
    .pick_o   (pick),
    .valid_o  (pick_valid)
  );

  // Slave-side mux; everything stays zero unless a grant is held.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_stb_o = 1'b0;
    s_cyc_o = 1'b0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        s_adr_o = m_adr_i[slice(k, ADR_W) +: ADR_W];
        s_dat_o = m_dat_i[slice(k, XLEN) +: XLEN];
        s_sel_o = m_sel_i[slice(k, 4) +: 4];
        s_we_o  = m_we_i[k];
        s_stb_o = m_stb_i[k];
        s_cyc_o = m_cyc_i[k];
      end
    end
  end

  // A same-cycle ack or err always beats the watchdog.
  assign stalled  = s_stb_o & ~s_ack_i & ~s_err_i;
  assign wd_fire  = stalled & (wd_cnt_q == WD_CNT_W'(TIMEOUT_CYCLES));
  assign wd_cnt_d = (stalled && !wd_fire) ? wd_cnt_q + WD_CNT_W'(1) : '0;

  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        m_ack_o[k] = s_ack_i;
        m_err_o[k] = s_err_i | wd_fire;
      end
    end
  end

  assign m_dat_o   = s_dat_i;
  assign timeout_o = wd_fire;
  assign grant_o   = grant_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_OWNED;
          grant_d = pick;
          for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (pick[k]) owner_d = PTR_W'(k);
          end
        end
      end
      ST_OWNED: begin
        if (!owner_active) begin
          state_d  = ST_RELEASE;
          grant_d  = '0;
          rr_ptr_d = (owner_q == PTR_W'(NUM_MASTERS - 1)) ? '0 : owner_q + PTR_W'(1);
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  a_grant_onehot0: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(grant_q));

endmodule

// File: tb/tb_rv32im_bus_arbiter.sv
// Directed bench for rv32im_bus_arbiter: a cycle model of the ownership and
// watchdog rules is compared every cycle, plus hand-computed spot checks.
module tb_rv32im_bus_arbiter;

  localparam int NM = 2;
  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [1:0]  req_i, grant_o, m_we_i, m_stb_i, m_cyc_i, m_ack_o, m_err_o;
  logic [59:0] m_adr_i;
  logic [63:0] m_dat_i;
  logic [7:0]  m_sel_i;
  logic [31:0] m_dat_o, s_dat_o, s_dat_i;
  logic [29:0] s_adr_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i, s_err_i, timeout_o;

  int tests = 0;
  int fails = 0;

  rv32im_bus_arbiter #(.XLEN(32), .NUM_MASTERS(NM), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .grant_o(grant_o),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .m_dat_o(m_dat_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Model: owner index (-1 when free), preferred next master, dead cycles
  // still to wait before arbitration, and consecutive stalled strobe cycles.
  int m_owner = -1;
  int m_pref  = 0;
  int m_wait  = 0;
  int m_run   = 0;

  always @(negedge clk_i) begin
    bit own, e_stb, stalled, fire;
    int o;
    logic [1:0] e_grant;
    if (reset_i) begin
      m_owner = -1; m_pref = 0; m_wait = 0; m_run = 0;
    end
    own     = (m_owner >= 0);
    o       = own ? m_owner : 0;
    e_grant = own ? 2'(1 << o) : 2'b00;
    e_stb   = own && m_stb_i[o];
    stalled = e_stb && !s_ack_i && !s_err_i;
    fire    = stalled && (m_run == TO);
    chk("grant", 64'(grant_o), 64'(e_grant));
    chk("s_adr", 64'(s_adr_o), own ? 64'(m_adr_i[o*30 +: 30]) : 64'd0);
    chk("s_dat", 64'(s_dat_o), own ? 64'(m_dat_i[o*32 +: 32]) : 64'd0);
    chk("s_sel", 64'(s_sel_o), own ? 64'(m_sel_i[o*4 +: 4]) : 64'd0);
    chk("s_we", 64'(s_we_o), 64'(own && m_we_i[o]));
    chk("s_stb", 64'(s_stb_o), 64'(e_stb));
    chk("s_cyc", 64'(s_cyc_o), 64'(own && m_cyc_i[o]));
    chk("m_ack", 64'(m_ack_o), (own && s_ack_i) ? 64'(e_grant) : 64'd0);
    chk("m_err", 64'(m_err_o), (own && (s_err_i || fire)) ? 64'(e_grant) : 64'd0);
    chk("timeout", 64'(timeout_o), 64'(fire));
    chk("m_dat", 64'(m_dat_o), 64'(s_dat_i));
    if (!reset_i) begin
      if (own) begin
        if (!(req_i[o] || m_cyc_i[o])) begin
          m_pref  = (o + 1) % NM;
          m_owner = -1;
          m_wait  = 1;
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end else begin
        for (int i = 0; i < NM; i++) begin
          if (m_owner < 0 && (req_i[(m_pref + i) % NM] || m_cyc_i[(m_pref + i) % NM]))
            m_owner = (m_pref + i) % NM;
        end
      end
      m_run = (stalled && !fire) ? m_run + 1 : 0;
    end
  end

  initial begin
    reset_i = 1'b0;
    req_i = '0; m_cyc_i = '0; m_stb_i = '0; m_we_i = 2'b10;
    m_adr_i = {30'h2AAA, 30'h1234};
    m_dat_i = {32'hB1B1_0001, 32'hA0A0_0000};
    m_sel_i = 8'h3F;
    s_dat_i = 32'hCAFE_0001; s_ack_i = 1'b0; s_err_i = 1'b0;
    #1 reset_i = 1'b1;
    #1;
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_stb", 64'(s_stb_o), 64'd0);
    chk("rst_ack", 64'(m_ack_o), 64'd0);
    chk("rst_timeout", 64'(timeout_o), 64'd0);
    step(); step();
    reset_i = 1'b0;

    // Stray ack while idle is dropped and starts nothing
    s_ack_i = 1'b1; #1;
    chk("stray_ack", 64'(m_ack_o), 64'd0);
    step(); s_ack_i = 1'b0; #1;
    chk("stray_grant", 64'(grant_o), 64'd0);

    // Single request from master 0
    req_i = 2'b01; m_cyc_i = 2'b01; m_stb_i = 2'b01;
    step();
    chk("t1_grant", 64'(grant_o), 64'h1);
    chk("t1_adr", 64'(s_adr_o), 64'h1234);
    chk("t1_dat", 64'(s_dat_o), 64'hA0A0_0000);
    step(); s_ack_i = 1'b1; #1;
    chk("t1_ack", 64'(m_ack_o), 64'h1);
    step(); s_ack_i = 1'b0; req_i = 2'b00; m_cyc_i = 2'b00; m_stb_i = 2'b00;
    step(); step(); step();

    // Simultaneous requests from a fresh reset
    reset_i = 1'b1; step(); reset_i = 1'b0;
    req_i = 2'b11; m_cyc_i = 2'b11;
    step(); #1;
    chk("t2_first", 64'(grant_o), 64'h1);
    step(); req_i = 2'b10; m_cyc_i = 2'b10;
    step(); #1;
    chk("t2_release", 64'(grant_o), 64'h0);
    req_i = 2'b11;
    step(); #1;
    chk("t2_idle", 64'(grant_o), 64'h0);
    step(); #1;
    chk("t2_handover", 64'(grant_o), 64'h2);

    // Master 1 holds ownership while master 0 waits
    for (int i = 0; i < 10; i++) begin
      step(); #1;
      chk("t3_hold", 64'(grant_o), 64'h2);
    end
    req_i = 2'b01; m_cyc_i = 2'b00;
    step(); #1; chk("t3_rel", 64'(grant_o), 64'h0);
    step(); #1; chk("t3_idle", 64'(grant_o), 64'h0);
    step(); #1; chk("t3_new", 64'(grant_o), 64'h1);

    // Watchdog: strobe with no ack fires on the ninth strobe cycle
    m_cyc_i = 2'b01; m_stb_i = 2'b01;
    repeat (TO) step();
    #1;
    chk("wd_err", 64'(m_err_o), 64'h1);
    chk("wd_pulse", 64'(timeout_o), 64'h1);
    step(); #1;
    chk("wd_pulse_end", 64'(timeout_o), 64'h0);
    chk("wd_err_end", 64'(m_err_o), 64'h0);
    repeat (TO) step();
    s_ack_i = 1'b1; #1;
    chk("wd_ack_wins_ack", 64'(m_ack_o), 64'h1);
    chk("wd_ack_wins_err", 64'(m_err_o), 64'h0);
    chk("wd_ack_wins_to", 64'(timeout_o), 64'h0);
    step(); s_ack_i = 1'b0; req_i = 2'b00; m_cyc_i = 2'b00; m_stb_i = 2'b00;

    // Async reset in the middle of a master 1 transfer
    req_i = 2'b10; m_cyc_i = 2'b10; m_stb_i = 2'b10;
    step(); step(); step(); #1;
    chk("t5_grant", 64'(grant_o), 64'h2);
    chk("t5_adr", 64'(s_adr_o), 64'h2AAA);
    chk("t5_sel", 64'(s_sel_o), 64'h3);
    reset_i = 1'b1; #1;
    chk("t5_rst_grant", 64'(grant_o), 64'h0);
    chk("t5_rst_stb", 64'(s_stb_o), 64'h0);
    chk("t5_rst_cyc", 64'(s_cyc_o), 64'h0);
    req_i = 2'b00; m_cyc_i = 2'b00; m_stb_i = 2'b00;
    step(); step();
    reset_i = 1'b0;
    req_i = 2'b11; m_cyc_i = 2'b11;
    step(); #1;
    chk("t5_after_rst", 64'(grant_o), 64'h1);
    step(); req_i = 2'b00; m_cyc_i = 2'b00;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
